// File: rtl/merge_add.sv
// merge_add -- tile-side elementwise adder for merge tiles.
//
// It collects merge_num operand vectors. Each vector is XW lanes of QW-bit
// signed values. The lanes are summed with signed saturation and one result
// vector is returned. All state is in the clk_tl domain.
//
// Optional feature: define MERGE_RELU_EN to clamp negative result lanes to 0
// before the result register. This adds no extra latency.
//
// Ports:
//   clk_tl       tile clock, rising edge
//   rst_tl       asynchronous active-high reset
//   in_data_i    operand vector, lane i at [i*QW +: QW]
//   in_valid_i   operand valid
//   in_ready_o   operand accepted when in_valid_i & in_ready_o
//   out_data_o   registered result vector, lanes >= valid_chans read 0
//   out_valid_o  result valid, held with stable data until handshake
//   out_ready_i  result consumed when out_valid_o & out_ready_i
module merge_add #(
   parameter int QW          = 8,
   parameter int XW          = 128,
   parameter int valid_chans = 128,
   parameter int merge_num   = 2
) (
   input  logic            clk_tl,
   input  logic            rst_tl,
   input  logic [QW*XW-1:0] in_data_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   output logic [QW*XW-1:0] out_data_o,
   output logic            out_valid_o,
   input  logic            out_ready_i
);

   localparam int AW = QW + $clog2(merge_num) + 1;
   localparam int CW = (merge_num > 1) ? $clog2(merge_num) : 1;

   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-QW+1){1'b0}}, {(QW-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-QW+1){1'b1}}, {(QW-1){1'b0}}};

   function automatic logic [QW-1:0] sat(input logic signed [AW-1:0] x);
      logic [QW-1:0] r;
      if (x > SAT_MAX)
         r = SAT_MAX[QW-1:0];
      else if (x < SAT_MIN)
         r = SAT_MIN[QW-1:0];
      else
         r = x[QW-1:0];
`ifdef MERGE_RELU_EN
      if (r[QW-1])
         r = '0;
`endif
      return r;
   endfunction

   logic [CW-1:0]          cnt;
   logic signed [AW-1:0]   acc [XW];
   logic signed [AW-1:0]   sum [XW];
   logic [QW*XW-1:0]       res;
   logic                   accept;
   logic                   last;

   // A held result blocks intake, so partial sums never build up behind it.
   assign in_ready_o = ~out_valid_o | out_ready_i;
   assign accept     = in_valid_i & in_ready_o;
   assign last       = (merge_num == 1) || (cnt == CW'(merge_num - 1));

   for (genvar g = 0; g < XW; g++) begin : g_lane
      logic signed [QW-1:0] op;
      // Inactive lanes contribute 0, so their acc and res stay at 0.
      assign op = (g < valid_chans) ? in_data_i[g*QW +: QW] : '0;
      // The first operand of a group starts from 0. This discards any stale acc.
      assign sum[g] = ((cnt == '0) ? '0 : acc[g]) + {{(AW-QW){op[QW-1]}}, op};
      assign out_data_o[g*QW +: QW] = (g < valid_chans) ? res[g*QW +: QW] : '0;
   end

   always_ff @(posedge clk_tl or posedge rst_tl) begin
      if (rst_tl) begin
         cnt         <= '0;
         out_valid_o <= 1'b0;
         res         <= '0;
         for (int i = 0; i < XW; i++)
            acc[i] <= '0;
      end else begin
         if (accept) begin
            if (last) begin
               cnt <= '0;
               for (int i = 0; i < XW; i++)
                  res[i*QW +: QW] <= sat(sum[i]);
            end else begin
               cnt <= cnt + 1'b1;
               for (int i = 0; i < XW; i++)
                  acc[i] <= sum[i];
            end
         end
         // A last accept that coincides with a handshake keeps valid high.
         // There is no bubble in that case.
         if (accept && last)
            out_valid_o <= 1'b1;
         else if (out_valid_o && out_ready_i)
            out_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_merge_add.sv
// tb_merge_add -- directed self-checking bench for merge_add.
// Instances: a (merge_num=2, all lanes), b (merge_num=3, valid_chans=4),
// c (merge_num=1, result every accept). All use QW=8, XW=8.
module tb_merge_add;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] a_din, a_dout, b_din, b_dout, c_din, c_dout;
   logic        a_vin, a_rdy, a_vout, a_rin;
   logic        b_vin, b_rdy, b_vout, b_rin;
   logic        c_vin, c_rdy, c_vout, c_rin;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   merge_add #(.QW(8), .XW(8), .valid_chans(8), .merge_num(2)) dut_a (
      .clk_tl(clk), .rst_tl(rst), .in_data_i(a_din), .in_valid_i(a_vin),
      .in_ready_o(a_rdy), .out_data_o(a_dout), .out_valid_o(a_vout), .out_ready_i(a_rin));

   merge_add #(.QW(8), .XW(8), .valid_chans(4), .merge_num(3)) dut_b (
      .clk_tl(clk), .rst_tl(rst), .in_data_i(b_din), .in_valid_i(b_vin),
      .in_ready_o(b_rdy), .out_data_o(b_dout), .out_valid_o(b_vout), .out_ready_i(b_rin));

   merge_add #(.QW(8), .XW(8), .valid_chans(8), .merge_num(1)) dut_c (
      .clk_tl(clk), .rst_tl(rst), .in_data_i(c_din), .in_valid_i(c_vin),
      .in_ready_o(c_rdy), .out_data_o(c_dout), .out_valid_o(c_vout), .out_ready_i(c_rin));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick; tick;
      checks++;
      if (a_vout !== 1'b0 || a_dout !== 64'h0 || a_rdy !== 1'b1) begin
         failures++;
         $display("FAIL reset_a vout=%b data=%h rdy=%b exp vout=0 data=0 rdy=1", a_vout, a_dout, a_rdy);
      end
      checks++;
      if (b_vout !== 1'b0 || b_dout !== 64'h0 || c_vout !== 1'b0 || c_dout !== 64'h0) begin
         failures++;
         $display("FAIL reset_bc b_vout=%b b_data=%h c_vout=%b c_data=%h exp all 0", b_vout, b_dout, c_vout, c_dout);
      end
      rst = 1'b0;
      tick;
   endtask

   task automatic test_basic;
      a_rin = 1'b1;
      a_vin = 1'b1; a_din = 64'h64;
      tick;
      checks++;
      if (a_vout !== 1'b0) begin
         failures++;
         $display("FAIL basic_early vout=%b exp 0", a_vout);
      end
      a_din = 64'h1B;
      tick;
      a_vin = 1'b0;
      checks++;
      if (a_vout !== 1'b1 || a_dout !== 64'h7F) begin
         failures++;
         $display("FAIL basic_result vout=%b data=%h exp vout=1 data=7f", a_vout, a_dout);
      end
      tick;
      checks++;
      if (a_vout !== 1'b0) begin
         failures++;
         $display("FAIL basic_one_cycle vout=%b exp 0", a_vout);
      end
   endtask

   task automatic test_saturate;
      logic [63:0] exp_v;
`ifdef MERGE_RELU_EN
      exp_v = 64'h0000_0000_0014_007F;
`else
      exp_v = 64'h0000_0000_F914_807F;
`endif
      a_rin = 1'b1;
      a_vin = 1'b1; a_din = 64'h0000_0000_F632_9C64;
      tick;
      a_din = 64'h0000_0000_03E2_9C64;
      tick;
      a_vin = 1'b0;
      checks++;
      if (a_vout !== 1'b1 || a_dout !== exp_v) begin
         failures++;
         $display("FAIL saturate vout=%b data=%h exp vout=1 data=%h", a_vout, a_dout, exp_v);
      end
      tick;
   endtask

   task automatic test_valid_chans;
      b_rin = 1'b1;
      b_vin = 1'b1;
      b_din = 64'h0101_0101_0101_0101; tick;
      checks++;
      if (b_vout !== 1'b0) begin
         failures++;
         $display("FAIL chans_early1 vout=%b exp 0", b_vout);
      end
      b_din = 64'h0202_0202_0202_0202; tick;
      checks++;
      if (b_vout !== 1'b0) begin
         failures++;
         $display("FAIL chans_early2 vout=%b exp 0", b_vout);
      end
      b_din = 64'h0303_0303_0303_0303; tick;
      b_vin = 1'b0;
      checks++;
      if (b_vout !== 1'b1 || b_dout !== 64'h0000_0000_0606_0606) begin
         failures++;
         $display("FAIL chans_result vout=%b data=%h exp vout=1 data=0000000006060606", b_vout, b_dout);
      end
      tick;
   endtask

   task automatic test_stall;
      a_rin = 1'b0;
      a_vin = 1'b1; a_din = 64'h0A; tick;
      a_din = 64'h14; tick;
      a_din = 64'h63;
      checks++;
      if (a_vout !== 1'b1 || a_dout !== 64'h1E || a_rdy !== 1'b0) begin
         failures++;
         $display("FAIL stall_start vout=%b data=%h rdy=%b exp vout=1 data=1e rdy=0", a_vout, a_dout, a_rdy);
      end
      for (int k = 0; k < 10; k++) begin
         tick;
         checks++;
         if (a_vout !== 1'b1 || a_dout !== 64'h1E || a_rdy !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold cyc=%0d vout=%b data=%h rdy=%b exp vout=1 data=1e rdy=0", k, a_vout, a_dout, a_rdy);
         end
      end
      a_vin = 1'b0;
      a_rin = 1'b1;
      #1;
      checks++;
      if (a_rdy !== 1'b1) begin
         failures++;
         $display("FAIL stall_release_rdy rdy=%b exp 1", a_rdy);
      end
      tick;
      checks++;
      if (a_vout !== 1'b0) begin
         failures++;
         $display("FAIL stall_handshake vout=%b exp 0", a_vout);
      end
      a_vin = 1'b1; a_din = 64'h01; tick;
      a_din = 64'h02; tick;
      a_vin = 1'b0;
      checks++;
      if (a_vout !== 1'b1 || a_dout !== 64'h03) begin
         failures++;
         $display("FAIL stall_no_consume vout=%b data=%h exp vout=1 data=03", a_vout, a_dout);
      end
      tick;
   endtask

   task automatic test_back_to_back;
      a_rin = 1'b1;
      a_vin = 1'b1;
      for (int k = 0; k < 8; k++) begin
         a_din = 64'(k + 1);
         tick;
         checks++;
         if (k % 2 == 1) begin
            if (a_vout !== 1'b1 || a_dout !== 64'(2 * k + 1) || a_rdy !== 1'b1) begin
               failures++;
               $display("FAIL b2b_result k=%0d vout=%b data=%h rdy=%b exp vout=1 data=%h rdy=1", k, a_vout, a_dout, a_rdy, 64'(2 * k + 1));
            end
         end else begin
            if (a_vout !== 1'b0 || a_rdy !== 1'b1) begin
               failures++;
               $display("FAIL b2b_gap k=%0d vout=%b rdy=%b exp vout=0 rdy=1", k, a_vout, a_rdy);
            end
         end
      end
      a_vin = 1'b0;
      tick;
      // merge_num=1 makes every handshake coincide with a last accept.
      c_rin = 1'b1;
      c_vin = 1'b1;
      for (int k = 0; k < 3; k++) begin
         c_din = 64'(5 + 2 * k);
         tick;
         checks++;
         if (c_vout !== 1'b1 || c_dout !== 64'(5 + 2 * k) || c_rdy !== 1'b1) begin
            failures++;
            $display("FAIL overlap k=%0d vout=%b data=%h rdy=%b exp vout=1 data=%h rdy=1", k, c_vout, c_dout, c_rdy, 64'(5 + 2 * k));
         end
      end
      c_rin = 1'b0;
      c_din = 64'h0B;
      tick;
      checks++;
      if (c_vout !== 1'b1 || c_dout !== 64'h09 || c_rdy !== 1'b0) begin
         failures++;
         $display("FAIL overlap_stall vout=%b data=%h rdy=%b exp vout=1 data=09 rdy=0", c_vout, c_dout, c_rdy);
      end
      c_vin = 1'b0;
   endtask

   task automatic test_reset_mid;
      a_rin = 1'b0;
      a_vin = 1'b1; a_din = 64'h07; tick;
      a_din = 64'h08; tick;
      a_vin = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (a_vout !== 1'b0 || a_dout !== 64'h0 || a_rdy !== 1'b1 || c_vout !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold a_vout=%b a_data=%h a_rdy=%b c_vout=%b exp 0,0,1,0", a_vout, a_dout, a_rdy, c_vout);
      end
      tick;
      rst = 1'b0;
      a_rin = 1'b1;
      tick;
      a_vin = 1'b1; a_din = 64'h32; tick;
      a_vin = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (a_vout !== 1'b0 || a_dout !== 64'h0 || a_rdy !== 1'b1) begin
         failures++;
         $display("FAIL reset_accum vout=%b data=%h rdy=%b exp vout=0 data=0 rdy=1", a_vout, a_dout, a_rdy);
      end
      tick;
      rst = 1'b0;
      tick;
      a_vin = 1'b1; a_din = 64'h05; tick;
      checks++;
      if (a_vout !== 1'b0) begin
         failures++;
         $display("FAIL reset_fresh_early vout=%b exp 0", a_vout);
      end
      a_din = 64'h06; tick;
      a_vin = 1'b0;
      checks++;
      if (a_vout !== 1'b1 || a_dout !== 64'h0B) begin
         failures++;
         $display("FAIL reset_fresh vout=%b data=%h exp vout=1 data=0b", a_vout, a_dout);
      end
      tick;
   endtask

   initial begin
      rst = 1'b1;
      a_din = '0; a_vin = 1'b0; a_rin = 1'b1;
      b_din = '0; b_vin = 1'b0; b_rin = 1'b1;
      c_din = '0; c_vin = 1'b0; c_rin = 1'b1;
      test_reset;
      test_basic;
      test_saturate;
      test_valid_chans;
      test_stall;
      test_back_to_back;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/merge_add.md
# merge_add

Tile-side elementwise adder for merge tiles. It accepts `merge_num` consecutive full-width vectors from merge_io's tile-side output (tl_data_o/tl_valid_o/tl_ready_i), sums them lane by lane with signed saturation, and returns one result vector to merge_io's tile-side input (tl_data_i/tl_valid_i/tl_ready_o). Everything runs in the tile clock domain; the network CDC stays inside merge_io.

## Interface
- `valid_chans`, default 128: active lanes, 1..`XW`; lanes ≥ valid_chans are ignored on input and driven 0 on output.
- `merge_num`, default 2: vectors summed per result, 1..16.
- `clk_tl` input 1: tile clock; all state on its rising edge.
- `rst_tl` input 1: reset, asynchronous, active-high.
- `in_data_i` input `QW` × `XW`: operand vector, signed two's complement per lane.
- `in_valid_i` input 1: operand valid.
- `in_ready_o` output 1: operand accepted when in_valid_i & in_ready_o.
- `out_data_o` output `QW` × `XW`: result vector, registered.
- `out_valid_o` output 1: result valid.
- `out_ready_i` input 1: result consumed when out_valid_o & out_ready_i.

## Operation
- Per-lane accumulator `acc[i]`, width AW = `QW` + $clog2(merge_num) + 1, signed. No overflow is possible before saturation.
- Operand counter `cnt`, 0..merge_num-1. Result register `res[i]`, QW bits. Flag `out_valid_o`.
- Accept with cnt==0: acc ← sext(in), cnt ← 1. When merge_num==1, this is also the last accept.
- Accept with 0<cnt<merge_num-1: acc ← acc + sext(in), cnt ← cnt+1.
- Last accept (cnt==merge_num-1): res ← sat(acc + sext(in)), where acc counts as 0 when merge_num==1. cnt ← 0 and out_valid_o ← 1.
- sat(x): clamp to [-2^(QW-1), 2^(QW-1)-1].
- Effective state machine: ACC (out_valid_o=0) → FULL (out_valid_o=1). On a result handshake: FULL → ACC, or stays FULL if a last accept happens in the same cycle.
- in_ready_o = ~out_valid_o | out_ready_i (combinational). A stalled result blocks all operand intake, so no partial sums accumulate behind it.
- out_valid_o is held with out_data_o stable until handshake. merge_io serialises over valid_chans cycles and asserts ready only on the final lane, so a stable hold is mandatory.
- out_data_o[i] = res[i] for i < valid_chans, else 0.

## Timing
- Reset (async assert, release synchronous to clk_tl): acc=0, cnt=0, res=0, out_valid_o=0, out_data_o=0, in_ready_o=1.
- Reset mid-accumulation or mid-hold discards the partial sum and any pending result. No output follows reset until merge_num fresh operands arrive.
- Latency: out_valid_o rises the cycle after the last operand handshake.
- Throughput: one operand per cycle. With out_ready_i tied 1, one result every merge_num cycles.
- A result handshake and a last accept in the same cycle load res with the new sum and keep out_valid_o=1, with no bubble.
- A result handshake and a non-last accept in the same cycle: out_valid_o falls and accumulation proceeds.
- in_valid_i low for any number of cycles is a pure stall; cnt and acc hold.

## Configuration
- `MERGE_RELU_EN` defined: the result register is loaded with max(sat(sum), 0) per lane, so negative lanes become 0.
- Not defined: the saturated signed sum is stored unchanged. No extra logic or latency in either mode.

## Test plan
- merge_num=2, QW=8, lane0 operands 100 then 27, out_ready_i=1 → lane0 result 127, out_valid_o for 1 cycle, 1 cycle after the 2nd accept.
- merge_num=2, lane0 100+100 and lane1 -100+-100 → 127 and -128 (saturated). With `MERGE_RELU_EN`: 127 and 0.
- merge_num=3, valid_chans=4, operands 1,2,3 in all lanes → lanes 0..3 = 6, lanes 4..XW-1 = 0.
- out_ready_i=0 for 10 cycles after result → out_valid_o and out_data_o stable, in_ready_o=0 throughout, no operand consumed. Release → handshake, in_ready_o=1.
- Continuous in_valid_i=1, out_ready_i=1, merge_num=2 → back-to-back results every 2 cycles; overlapping handshake/last-accept never drops a vector.
- Assert rst_tl after 1 of 2 operands → all outputs 0 immediately. Next two operands 5,6 → result 11, not including the pre-reset operand.
